// File: rtl/uart_rom_loader.sv
// UART (8N1) program loader: receives a framed image (A5, count, words) and
// streams 16-bit writes into the instruction RAM while holding `loading` high.
module uart_rom_loader #(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_WORDS    = 4096,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rx,
  output logic                  wrEn,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [15:0]           wrData,
  output logic                  loading,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           byteCount
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]   MAX_W     = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, DONE, ERROR} ld_state_t;

  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t       r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]   r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_rx_valid, w_frame_err;
  logic [7:0]      w_rx_byte;
  logic [15:0]     r_byte_count;

  ld_state_t       r_state, w_state_nxt;
  logic [7:0]      r_hi, w_hi_nxt;
  logic [15:0]     r_remaining, w_remaining_nxt;
  logic [15:0]     w_count;
  logic [TW-1:0]   r_idle_cnt, w_idle_cnt_nxt;
  logic            r_wr_en, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [15:0]     r_wr_data, w_wr_data_nxt;
  logic            r_loading, w_loading_nxt;
  logic            r_done, w_done_nxt;
  logic            r_error, w_error_nxt;
  logic            w_active;

  assign w_rx_byte = r_shift;
  assign w_count   = {r_hi, w_rx_byte};
  assign w_active  = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                     (r_state == DAT_HI) || (r_state == DAT_LO);

  // Synchroniser resets to the idle-high line level so release never fakes a start edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= {CW{1'b0}};
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_count <= 16'd0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_rx_state   <= w_rx_state_nxt;
      r_clk_cnt    <= w_clk_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_count <= w_rx_valid ? r_byte_count + 16'd1 : r_byte_count;
    end
  end

  // Receiver: mid-bit sampling, glitch rejection at the start-bit midpoint.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_clk_cnt_nxt  = r_clk_cnt + CW'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_rx_valid     = 1'b0;
    w_frame_err    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_clk_cnt_nxt = {CW{1'b0}};
        if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = RX_START;
        else                         w_rx_state_nxt = RX_IDLE;
      end
      RX_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_nxt  = {CW{1'b0}};
          w_bit_idx_nxt  = 3'd0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = {CW{1'b0}};
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
          else                   w_bit_idx_nxt  = r_bit_idx + 3'd1;
        end else begin
          w_rx_state_nxt = RX_DATA;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_rx_state_nxt = RX_IDLE;
          if (r_rx_sync) w_rx_valid  = 1'b1;
          else           w_frame_err = 1'b1;
        end else begin
          w_rx_state_nxt = RX_STOP;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Loader state and registered write-port outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= IDLE;
      r_hi        <= 8'd0;
      r_remaining <= 16'd0;
      r_idle_cnt  <= {TW{1'b0}};
      r_wr_en     <= 1'b0;
      r_wr_addr   <= {ADDR_WIDTH{1'b0}};
      r_wr_data   <= 16'd0;
      r_loading   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hi        <= w_hi_nxt;
      r_remaining <= w_remaining_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_loading   <= w_loading_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  // After the last word the FSM is already in DONE while wrEn is high; loading/done flip as it drops.
  always_comb begin
    w_state_nxt     = r_state;
    w_hi_nxt        = r_hi;
    w_remaining_nxt = r_remaining;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_loading_nxt   = r_loading;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_idle_cnt_nxt  = (w_active && !w_rx_valid) ? r_idle_cnt + TW'(1) : {TW{1'b0}};

    if (r_wr_en) begin
      w_wr_addr_nxt = r_wr_addr + ADDR_WIDTH'(1);
      if (r_state == DONE) begin
        w_loading_nxt = 1'b0;
        w_done_nxt    = 1'b1;
      end else begin
        w_loading_nxt = r_loading;
      end
    end else begin
      w_wr_addr_nxt = r_wr_addr;
    end

    case (r_state)
      IDLE, DONE, ERROR: begin
        if (w_rx_valid && (w_rx_byte == 8'hA5)) begin
          w_state_nxt   = CNT_HI;
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_loading_nxt = 1'b1;
          w_wr_addr_nxt = {ADDR_WIDTH{1'b0}};
        end else begin
          w_state_nxt = r_state;
        end
      end
      CNT_HI: begin
        if (w_rx_valid) begin
          w_hi_nxt    = w_rx_byte;
          w_state_nxt = CNT_LO;
        end else begin
          w_state_nxt = CNT_HI;
        end
      end
      CNT_LO: begin
        if (w_rx_valid) begin
          if (w_count == 16'd0) begin
            w_state_nxt   = DONE;
            w_loading_nxt = 1'b0;
            w_done_nxt    = 1'b1;
          end else if ({1'b0, w_count} > MAX_W) begin
            w_state_nxt   = ERROR;
            w_loading_nxt = 1'b0;
            w_error_nxt   = 1'b1;
          end else begin
            w_remaining_nxt = w_count;
            w_state_nxt     = DAT_HI;
          end
        end else begin
          w_state_nxt = CNT_LO;
        end
      end
      DAT_HI: begin
        if (w_rx_valid) begin
          w_hi_nxt    = w_rx_byte;
          w_state_nxt = DAT_LO;
        end else begin
          w_state_nxt = DAT_HI;
        end
      end
      DAT_LO: begin
        if (w_rx_valid) begin
          w_wr_en_nxt     = 1'b1;
          w_wr_data_nxt   = {r_hi, w_rx_byte};
          w_remaining_nxt = r_remaining - 16'd1;
          w_state_nxt     = (r_remaining == 16'd1) ? DONE : DAT_HI;
        end else begin
          w_state_nxt = DAT_LO;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_active && (w_frame_err || (!w_rx_valid && (r_idle_cnt == TO_LAST)))) begin
      w_state_nxt   = ERROR;
      w_loading_nxt = 1'b0;
      w_error_nxt   = 1'b1;
      w_wr_en_nxt   = 1'b0;
    end else begin
      w_idle_cnt_nxt = w_idle_cnt_nxt;
    end
  end

  assign wrEn      = r_wr_en;
  assign wrAddr    = r_wr_addr;
  assign wrData    = r_wr_data;
  assign loading   = r_loading;
  assign done      = r_done;
  assign error     = r_error;
  assign byteCount = r_byte_count;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: serial images against a byte-level image model.
module tb_uart_rom_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [31:0] wr_q_t[$];

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        rx = 1'b1;
  logic        wrEn, loading, done, error;
  logic [15:0] wrAddr, wrData, byteCount;

  wr_q_t got_w, exp_w;
  bit    m_done, m_err, m_open;
  int    exp_bytes = 0;
  int    n_total = 0, n_pass = 0;
  int    viol = 0;
  logic        prev_en = 1'b0;
  logic [15:0] prev_addr = 16'd0;

  uart_rom_loader #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_WIDTH(16),
                    .MAX_WORDS(8), .TIMEOUT_CLKS(200)) dut (
    .clk(clk), .rstN(rstN), .rx(rx), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .loading(loading), .done(done), .error(error),
    .byteCount(byteCount));

  always #5 clk = ~clk;

  // Write-port monitor: records writes and counts strobe/address-rule violations.
  always @(negedge clk) begin
    if (rstN) begin
      if (wrEn) got_w.push_back({wrAddr, wrData});
      if (wrEn && prev_en) viol++;
      if (wrEn && !loading) viol++;
      if (prev_en && (wrAddr !== prev_addr + 16'd1)) viol++;
      prev_en = wrEn;
      prev_addr = wrAddr;
    end else begin
      prev_en = 1'b0;
    end
  end

  function automatic string q2s(input wr_q_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  // Image rules at byte granularity: find sync, read count, collect words.
  task automatic model_stream(input byte_q_t b);
    int i = 0;
    int cnt;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
      end else begin
        m_done = 0; m_err = 0; m_open = 1;
        if (i + 2 >= b.size()) return;
        cnt = {b[i+1], b[i+2]};
        i += 3;
        if (cnt == 0) begin
          m_done = 1; m_open = 0;
        end else if (cnt > 8) begin
          m_err = 1; m_open = 0;
        end else begin
          for (int j = 0; j < cnt; j++) begin
            if (i + 1 >= b.size()) return;
            exp_w.push_back({16'(j), b[i], b[i+1]});
            i += 2;
          end
          m_done = 1; m_open = 0;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_stream(input byte_q_t b);
    foreach (b[i]) send_byte(b[i], 1'b1);
    exp_bytes += b.size();
  endtask

  task automatic clear_q();
    got_w.delete();
    exp_w.delete();
  endtask

  task automatic test_reset();
    rstN = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({wrEn, wrAddr, wrData, loading, done, error, byteCount} !== 52'd0)
      $display("FAIL reset_hold: got %h want 0", {wrEn, wrAddr, wrData, loading, done, error, byteCount});
    else n_pass++;
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if ({wrEn, wrAddr, wrData, loading, done, error, byteCount} !== 52'd0)
      $display("FAIL reset_release: got %h want 0", {wrEn, wrAddr, wrData, loading, done, error, byteCount});
    else n_pass++;
  endtask

  task automatic test_basic_load();
    byte_q_t s = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    clear_q(); viol = 0;
    model_stream(s); send_stream(s);
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL basic writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if (done !== m_done) $display("FAIL basic done: got %b want %b", done, m_done); else n_pass++;
    n_total++; if (loading !== m_open) $display("FAIL basic loading: got %b want %b", loading, m_open); else n_pass++;
    n_total++; if (error !== m_err) $display("FAIL basic error: got %b want %b", error, m_err); else n_pass++;
    n_total++; if (byteCount !== 16'(exp_bytes)) $display("FAIL basic bytecount: got %0d want %0d", byteCount, exp_bytes); else n_pass++;
    n_total++; if (viol != 0) $display("FAIL basic strobe_rules: got %0d violations want 0", viol); else n_pass++;
  endtask

  task automatic test_ignore_prefix();
    byte_q_t s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    clear_q();
    rstN = 1'b0; #1; exp_bytes = 0; m_done = 0; m_err = 0; m_open = 0;
    @(negedge clk) rstN = 1'b1;
    model_stream(s); send_stream(s);
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL prefix writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if (done !== m_done) $display("FAIL prefix done: got %b want %b", done, m_done); else n_pass++;
    n_total++; if (byteCount !== 16'(exp_bytes)) $display("FAIL prefix bytecount: got %0d want %0d", byteCount, exp_bytes); else n_pass++;
  endtask

  task automatic test_oversize_recover();
    byte_q_t s1 = '{8'hA5, 8'h00, 8'h09};
    byte_q_t s2 = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
    clear_q();
    model_stream(s1); send_stream(s1);
    n_total++; if (error !== m_err) $display("FAIL oversize error: got %b want %b", error, m_err); else n_pass++;
    n_total++; if (loading !== m_open) $display("FAIL oversize loading: got %b want %b", loading, m_open); else n_pass++;
    n_total++; if (got_w.size() != exp_w.size()) $display("FAIL oversize writes: got %0d want %0d", got_w.size(), exp_w.size()); else n_pass++;
    model_stream(s2); send_stream(s2);
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL recover writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if ({done, error} !== {m_done, m_err}) $display("FAIL recover flags: got %b want %b", {done, error}, {m_done, m_err}); else n_pass++;
  endtask

  task automatic test_timeout();
    byte_q_t s = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};
    clear_q();
    model_stream(s); send_stream(s);
    n_total++; if (loading !== m_open) $display("FAIL timeout pre_loading: got %b want %b", loading, m_open); else n_pass++;
    repeat (300) @(negedge clk);
    if (m_open) begin m_err = 1; m_open = 0; end
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL timeout writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if ({error, loading, done} !== {m_err, m_open, m_done}) $display("FAIL timeout flags: got %b want %b", {error, loading, done}, {m_err, m_open, m_done}); else n_pass++;
  endtask

  task automatic test_framing_glitch();
    byte_q_t s = '{8'hA5, 8'h00, 8'h01};
    int bc;
    clear_q();
    model_stream(s); send_stream(s);
    send_byte(8'h55, 1'b0);
    m_err = 1; m_open = 0;
    n_total++; if ({error, loading} !== {m_err, m_open}) $display("FAIL framing flags: got %b want %b", {error, loading}, {m_err, m_open}); else n_pass++;
    n_total++; if (got_w.size() != exp_w.size()) $display("FAIL framing writes: got %0d want %0d", got_w.size(), exp_w.size()); else n_pass++;
    n_total++; if (byteCount !== 16'(exp_bytes)) $display("FAIL framing bytecount: got %0d want %0d", byteCount, exp_bytes); else n_pass++;
    bc = exp_bytes;
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    n_total++; if (byteCount !== 16'(bc)) $display("FAIL glitch bytecount: got %0d want %0d", byteCount, bc); else n_pass++;
    n_total++; if (error !== m_err) $display("FAIL glitch error: got %b want %b", error, m_err); else n_pass++;
  endtask

  task automatic test_random();
    byte_q_t s;
    logic [15:0] w;
    logic [7:0]  j;
    int len;
    for (int it = 0; it < 6; it++) begin
      clear_q(); viol = 0;
      s.delete();
      for (int p = 0; p < $urandom_range(0, 2); p++) begin
        j = 8'($urandom_range(0, 255));
        s.push_back((j == 8'hA5) ? 8'h5A : j);
      end
      len = $urandom_range(0, 10);
      s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'(len));
      if (len <= 8)
        for (int k = 0; k < len; k++) begin
          w = 16'($urandom_range(0, 65535));
          s.push_back(w[15:8]); s.push_back(w[7:0]);
        end
      model_stream(s); send_stream(s);
      n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL random%0d writes: got %s want %s", it, q2s(got_w), q2s(exp_w)); else n_pass++;
      n_total++; if ({done, error, loading} !== {m_done, m_err, m_open}) $display("FAIL random%0d flags: got %b want %b", it, {done, error, loading}, {m_done, m_err, m_open}); else n_pass++;
      n_total++; if (byteCount !== 16'(exp_bytes)) $display("FAIL random%0d bytecount: got %0d want %0d", it, byteCount, exp_bytes); else n_pass++;
      n_total++; if (viol != 0) $display("FAIL random%0d strobe_rules: got %0d want 0", it, viol); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t s;
    logic [15:0] w;
    int len;
    clear_q(); viol = 0;
    for (int img = 0; img < 2; img++) begin
      len = $urandom_range(1, 4);
      s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'(len));
      for (int k = 0; k < len; k++) begin
        w = (k == 0) ? 16'hA5A5 : 16'($urandom_range(0, 65535));
        s.push_back(w[15:8]); s.push_back(w[7:0]);
      end
    end
    model_stream(s); send_stream(s);
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL b2b writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if ({done, error, loading} !== {m_done, m_err, m_open}) $display("FAIL b2b flags: got %b want %b", {done, error, loading}, {m_done, m_err, m_open}); else n_pass++;
    n_total++; if (viol != 0) $display("FAIL b2b strobe_rules: got %0d want 0", viol); else n_pass++;
  endtask

  task automatic test_reset_midload();
    byte_q_t s = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02};
    clear_q();
    model_stream(s); send_stream(s);
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL midrst pre_writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if (loading !== m_open) $display("FAIL midrst pre_loading: got %b want %b", loading, m_open); else n_pass++;
    @(negedge clk) rx = 1'b0;
    repeat (25) @(negedge clk);
    rstN = 1'b0;
    #1;
    n_total++;
    if ({wrEn, wrAddr, wrData, loading, done, error, byteCount} !== 52'd0)
      $display("FAIL midrst outputs: got %h want 0", {wrEn, wrAddr, wrData, loading, done, error, byteCount});
    else n_pass++;
    clear_q(); exp_bytes = 0; m_done = 0; m_err = 0; m_open = 0;
    @(negedge clk) rx = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (300) @(negedge clk);
    n_total++; if (q2s(got_w) != q2s(exp_w)) $display("FAIL midrst post_writes: got %s want %s", q2s(got_w), q2s(exp_w)); else n_pass++;
    n_total++; if ({loading, done, error} !== {m_open, m_done, m_err}) $display("FAIL midrst post_flags: got %b want %b", {loading, done, error}, {m_open, m_done, m_err}); else n_pass++;
    n_total++; if (byteCount !== 16'(exp_bytes)) $display("FAIL midrst bytecount: got %0d want %0d", byteCount, exp_bytes); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_ignore_prefix();
    test_oversize_recover();
    test_timeout();
    test_framing_glitch();
    test_random();
    test_back_to_back();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
